uart_cmd_parser: RTL and testbench

//  Consumer end of the uart_const_baud byte interface. Collects 5-byte command

---
 rtl/uart_cmd_parser_if.sv | 27 ++
 rtl/uart_cmd_parser.sv | 206 ++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_if.sv
// Byte handshake bundle around uart_cmd_parser.
// slave  : the parser's view. It consumes RX bytes, produces TX bytes and register writes.
// master : the surrounding side, which is the UART, the register file or a testbench.
interface uart_cmd_parser_if;
  logic [7:0]  rx_data;
  logic        rx_rec_flag;
  logic        rx_clr;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        tx_idle;
  logic        reg_wr;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        frame_err;
  logic        busy;

  modport slave (
    input  rx_data, rx_rec_flag, tx_done, tx_idle,
    output rx_clr, tx_data, tx_start, reg_wr, reg_addr, reg_wdata, frame_err, busy
  );

  modport master (
    output rx_data, rx_rec_flag, tx_done, tx_idle,
    input  rx_clr, tx_data, tx_start, reg_wr, reg_addr, reg_wdata, frame_err, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: collects 5-byte frames {HDR, ADDR, DHI, DLO, CSUM} from the UART
// receiver and checks CSUM == ADDR+DHI+DLO (mod 256). A good frame issues one register
// write and an ACK reply. A bad frame pulses frame_err and sends a NAK reply.
// Optional feature: define UART_CMD_TIMEOUT_EN to drop a partial frame when the gap
// between two bytes reaches TIMEOUT_CYCLES-1 clocks. Without it, a partial frame waits
// indefinitely.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  HDR_BYTE       = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic             clk,
  input  logic             rst,
  uart_cmd_parser_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DHI,
    S_DLO,
    S_CSUM,
    S_EXEC,
    S_REPLY,
    S_WAIT_TX
  } state_e;

  state_e      state_q, state_d;
  logic        skip_q, skip_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  dhi_q, dhi_d;
  logic [7:0]  dlo_q, dlo_d;
  logic        reg_wr_q, reg_wr_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic        intake_state;
  logic        in_frame;
  logic        accept;
  logic        timeout;
  logic        tx_start;
  logic [7:0]  sum;

  // States that take bytes from the receiver. The other states leave bytes pending in the UART.
  assign intake_state = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DHI) ||
                        (state_q == S_DLO)  || (state_q == S_CSUM);
  assign in_frame     = (state_q == S_ADDR) || (state_q == S_DHI) ||
                        (state_q == S_DLO)  || (state_q == S_CSUM);

  // rx_rec_flag falls only one cycle after rx_clr. skip_q blocks that stale cycle.
  assign accept = intake_state && bus.rx_rec_flag && !skip_q;
  assign sum    = addr_q + dhi_q + dlo_q;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;

  // Inter-byte gap counter. It clears on each captured byte and outside a frame, and it saturates.
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (!in_frame || accept) begin
      gap_cnt_d = '0;
    end else if (gap_cnt_q != CNT_LAST) begin
      gap_cnt_d = gap_cnt_q + 1'b1;
    end
  end

  // Gap counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // A byte captured in the limit cycle still arrived in time, so it wins over the timeout.
  assign timeout = in_frame && !accept && (gap_cnt_q == CNT_LAST);
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic, byte capture, checksum decision and reply hand-off.
  always_comb begin
    // NOTE: every variable gets its default before the case statement, so no path can
    // leave a signal unassigned and infer a latch.
    state_d     = state_q;
    skip_d      = accept;
    addr_d      = addr_q;
    dhi_d       = dhi_q;
    dlo_d       = dlo_q;
    reg_wr_d    = 1'b0;
    frame_err_d = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    tx_data_d   = tx_data_q;
    tx_start    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && (bus.rx_data == HDR_BYTE)) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (accept) begin
          addr_d  = bus.rx_data;
          state_d = S_DHI;
        end
      end
      S_DHI: begin
        if (accept) begin
          dhi_d   = bus.rx_data;
          state_d = S_DLO;
        end
      end
      S_DLO: begin
        if (accept) begin
          dlo_d   = bus.rx_data;
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        // Decide here, so the write strobe and the new address/data are registered together into EXEC.
        if (accept) begin
          state_d = S_EXEC;
          if (bus.rx_data == sum) begin
            reg_wr_d    = 1'b1;
            reg_addr_d  = addr_q;
            reg_wdata_d = {dhi_q, dlo_q};
            tx_data_d   = ACK_BYTE;
          end else begin
            frame_err_d = 1'b1;
            tx_data_d   = NAK_BYTE;
          end
        end
      end
      S_EXEC: begin
        state_d = S_REPLY;
      end
      S_REPLY: begin
        if (bus.tx_idle) begin
          tx_start = 1'b1;
          state_d  = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (bus.tx_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (timeout) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end
  end

  // State, shadow and output registers. Synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples
    // pre-edge values.
    if (!rst) begin
      state_q     <= S_IDLE;
      skip_q      <= 1'b0;
      addr_q      <= '0;
      dhi_q       <= '0;
      dlo_q       <= '0;
      reg_wr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      addr_q      <= addr_d;
      dhi_q       <= dhi_d;
      dlo_q       <= dlo_d;
      reg_wr_q    <= reg_wr_d;
      frame_err_q <= frame_err_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign bus.rx_clr    = accept;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser. The bench contains a UART RX model that holds
// rx_rec_flag one cycle past the capture edge, and a UART TX model. A scoreboard holds
// the expected register writes and reply bytes.
module tb_uart_cmd_parser;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(.TIMEOUT_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_q[$];
  wr_t        exp_wr_q[$];
  logic [7:0] exp_tx_q[$];

  int n_wr = 0, n_tx = 0, n_ferr = 0, n_clr = 0;
  int exp_wr_n = 0, exp_tx_n = 0, exp_ferr_n = 0, exp_clr_n = 0;
  logic [7:0]  model_addr = 8'h00;
  logic [15:0] model_data = 16'h0000;
  int cyc = 0, last_clr_cyc = 0, ferr_cyc = 0;
  bit tx_hold = 1'b0;
  bit tx_busy = 1'b0;
  wr_t mon_wr;
  logic [7:0] mon_tx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor and scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (bus.rx_clr) begin
        n_clr++;
        last_clr_cyc = cyc;
      end
      if (bus.frame_err) begin
        n_ferr++;
        ferr_cyc = cyc;
      end
      if (bus.reg_wr) begin
        n_wr++;
        if (exp_wr_q.size() > 0) begin
          mon_wr = exp_wr_q.pop_front();
          check("wr_addr", 32'(bus.reg_addr), 32'(mon_wr.addr));
          check("wr_data", 32'(bus.reg_wdata), 32'(mon_wr.data));
        end else begin
          check("wr_unexpected", 32'(exp_wr_q.size()), 32'd1);
        end
      end
      if (bus.tx_start) begin
        n_tx++;
        if (exp_tx_q.size() > 0) begin
          mon_tx = exp_tx_q.pop_front();
          check("tx_byte", 32'(bus.tx_data), 32'(mon_tx));
        end else begin
          check("tx_unexpected", 32'(exp_tx_q.size()), 32'd1);
        end
      end
    end
  end

  // UART RX model: presents one byte and drops the flag one cycle after the capture edge.
  initial begin : rx_model
    bit got;
    bus.rx_data     = 8'h00;
    bus.rx_rec_flag = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst && rx_q.size() > 0) begin
        bus.rx_data     = rx_q.pop_front();
        bus.rx_rec_flag = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
          @(negedge clk);
          if (bus.rx_clr) got = 1'b1;
        end
        if (!got) check("rx_clr_wait", 32'(got), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.rx_rec_flag = 1'b0;
      end
    end
  end

  // UART TX model: each started byte keeps the transmitter busy for 20 cycles, then tx_done pulses.
  initial begin : tx_model
    bit start_seen;
    int tx_cnt;
    bus.tx_idle = 1'b1;
    bus.tx_done = 1'b0;
    tx_cnt = 0;
    forever begin
      @(negedge clk);
      start_seen = bus.tx_start;
      @(posedge clk);
      #1;
      bus.tx_done = 1'b0;
      if (start_seen) begin
        tx_busy = 1'b1;
        tx_cnt  = 20;
      end else if (tx_busy) begin
        if (tx_cnt == 0) begin
          bus.tx_done = 1'b1;
          tx_busy     = 1'b0;
        end else begin
          tx_cnt--;
        end
      end
      bus.tx_idle = !tx_busy && !tx_hold;
    end
  end

  task automatic push_rx(input logic [7:0] b);
    rx_q.push_back(b);
    exp_clr_n++;
  endtask

  // Predicts the outcome of a frame whose ADDR..CSUM bytes are a, dh, dl, cs.
  task automatic expect_frame(input logic [7:0] a, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] cs);
    logic [7:0] s;
    s = a + dh + dl;
    exp_tx_n++;
    if (cs == s) begin
      exp_wr_q.push_back({a, dh, dl});
      exp_tx_q.push_back(8'h06);
      exp_wr_n++;
      model_addr = a;
      model_data = {dh, dl};
    end else begin
      exp_tx_q.push_back(8'h15);
      exp_ferr_n++;
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] dh,
                            input logic [7:0] dl, input logic [7:0] cs);
    push_rx(8'hA5);
    push_rx(a);
    push_rx(dh);
    push_rx(dl);
    push_rx(cs);
    expect_frame(a, dh, dl, cs);
  endtask

  task automatic wait_rx_drained();
    int n;
    n = 0;
    while ((rx_q.size() > 0 || bus.rx_rec_flag) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("rx_drain_in_time", 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((rx_q.size() > 0 || bus.rx_rec_flag || bus.busy || tx_busy ||
            exp_wr_q.size() > 0 || exp_tx_q.size() > 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_in_time", 32'(n < 5000), 32'd1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_writes"}, 32'(n_wr), 32'(exp_wr_n));
    check({tag, "_replies"}, 32'(n_tx), 32'(exp_tx_n));
    check({tag, "_frame_errs"}, 32'(n_ferr), 32'(exp_ferr_n));
    check({tag, "_rx_clrs"}, 32'(n_clr), 32'(exp_clr_n));
    check({tag, "_reg_addr"}, 32'(bus.reg_addr), 32'(model_addr));
    check({tag, "_reg_wdata"}, 32'(bus.reg_wdata), 32'(model_data));
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_reg_wr"}, 32'(bus.reg_wr), 32'd0);
    check({tag, "_reg_addr"}, 32'(bus.reg_addr), 32'd0);
    check({tag, "_reg_wdata"}, 32'(bus.reg_wdata), 32'd0);
    check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    check({tag, "_rx_clr"}, 32'(bus.rx_clr), 32'd0);
  endtask

  initial begin : main
    int snap_tx;
    int snap_clr;
    int snap_ferr;
    int n;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet_outputs("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // 1: good frame
    send_frame(8'h10, 8'h12, 8'h34, 8'h56);
    wait_done();
    check_counts("good");

    // 2: bad checksum. No write, NAK, and the registers keep 0x10/0x1234.
    send_frame(8'h10, 8'h12, 8'h34, 8'h57);
    wait_done();
    check_counts("bad_csum");
    check("bad_csum_addr_held", 32'(bus.reg_addr), 32'h10);

    // 3: noise bytes are consumed and discarded, then a good frame follows
    push_rx(8'h00);
    push_rx(8'hFF);
    push_rx(8'h5A);
    send_frame(8'h10, 8'h12, 8'h34, 8'h56);
    wait_done();
    check_counts("noise");

    // 4: a partial frame followed by 200 idle cycles
    push_rx(8'hA5);
    push_rx(8'h10);
    wait_rx_drained();
    snap_tx = n_tx;
`ifdef UART_CMD_TIMEOUT_EN
    exp_ferr_n++;
    repeat (200) @(posedge clk);
    #1;
    check("timeout_ferr", 32'(n_ferr), 32'(exp_ferr_n));
    check("timeout_delay_window", 32'((ferr_cyc - last_clr_cyc) >= 98 &&
                                      (ferr_cyc - last_clr_cyc) <= 102), 32'd1);
    check("timeout_idle", 32'(bus.busy), 32'd0);
    check("timeout_no_tx", 32'(n_tx), 32'(snap_tx));
    send_frame(8'h20, 8'h00, 8'h01, 8'h21);
`else
    repeat (200) @(posedge clk);
    #1;
    check("partial_waits_busy", 32'(bus.busy), 32'd1);
    check("partial_no_ferr", 32'(n_ferr), 32'(exp_ferr_n));
    check("partial_no_tx", 32'(n_tx), 32'(snap_tx));
    push_rx(8'h12);
    push_rx(8'h34);
    push_rx(8'h56);
    expect_frame(8'h10, 8'h12, 8'h34, 8'h56);
`endif
    wait_done();
    check_counts("gap");

    // 5: reset in the middle of a frame
    push_rx(8'hA5);
    push_rx(8'h10);
    push_rx(8'h12);
    wait_rx_drained();
    check("midframe_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_quiet_outputs("midreset");
    model_addr = 8'h00;
    model_data = 16'h0000;
    send_frame(8'h01, 8'h00, 8'h02, 8'h03);
    wait_done();
    check_counts("after_reset");

    // 6: back-to-back frames while the transmitter reports not idle
    tx_hold = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'h30, 8'hAB, 8'hCD, 8'(8'h30 + 8'hAB + 8'hCD));
    send_frame(8'h31, 8'h01, 8'h02, 8'h34);
    snap_tx   = n_tx;
    snap_ferr = n_ferr;
    n = 0;
    while (n_wr < exp_wr_n - 1 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("b2b_first_write_in_time", 32'(n < 3000), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    snap_clr = n_clr;
    repeat (50) @(posedge clk);
    #1;
    check("b2b_tx_held", 32'(n_tx), 32'(snap_tx));
    check("b2b_busy_held", 32'(bus.busy), 32'd1);
    check("b2b_second_not_taken", 32'(n_clr), 32'(snap_clr));
    check("b2b_no_ferr", 32'(n_ferr), 32'(snap_ferr));
    tx_hold = 1'b0;
    wait_done();
    check_counts("b2b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
